alu_issue: RTL and testbench

Issue and write-back stage wrapped around the datapath ALU. Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8 x nbit register file. Drives the ALU operand, select and shift-in ports from registers, then captures the ALU result and writes it back to the destination register. Sits between the instruction source (testbench or fetch unit) and the combinational ALU; one instruction is in flight at a time.

---
 rtl/alu_issue_pkg.sv | 46 ++++
 rtl/alu_issue_if.sv | 30 +++
 rtl/alu_regfile.sv | 47 ++++
 rtl/alu_issue.sv | 134 +++++++++++++
 tb/tb_alu_issue.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/write-back stage: opcodes, instruction
// field positions, FSM state encoding and register file geometry.
package alu_issue_pkg;

  // ALU operation select codes
  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAndL = 3'b010,
    OpOrL  = 3'b011,
    OpXor  = 3'b100,
    OpNot  = 3'b101,
    OpShl  = 3'b110,
    OpShr  = 3'b111
  } alu_op_e;

  localparam int unsigned InstrWidth = 16;
  localparam int unsigned RegAddrW   = 3;
  localparam int unsigned NREGS      = 8;

  // Format select: 0 = ALU op, 1 = load-immediate
  localparam int unsigned InstrFmtBit = 15;

  // ALU op format: [14:12] sel, [11:9] rd, [8:6] rs1, [5:3] rs2, [2] shin
  localparam int unsigned OpSelLsb  = 12;
  localparam int unsigned OpRdLsb   = 9;
  localparam int unsigned OpRs1Lsb  = 6;
  localparam int unsigned OpRs2Lsb  = 3;
  localparam int unsigned OpShinBit = 2;

  // Load-immediate format: [14:12] rd, [7:0] imm
  localparam int unsigned LiRdLsb    = 12;
  localparam int unsigned LiImmLsb   = 0;
  localparam int unsigned LiImmWidth = 8;

  // FSM state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  // True when the word uses the load-immediate format
  function automatic logic is_load_imm(input logic [InstrWidth-1:0] word);
    return word[InstrFmtBit];
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's handshake, ALU-side and debug signals.
interface alu_issue_if #(
  parameter int unsigned nbit = 16
);
  logic            in_valid;
  logic [15:0]     in_instr;
  logic            in_ready;
  logic [nbit-1:0] alu_a;
  logic [nbit-1:0] alu_b;
  logic [2:0]      alu_sel;
  logic            alu_shin;
  logic [nbit-1:0] alu_result;
  logic            wb_valid;
  logic [2:0]      wb_rd;
  logic [nbit-1:0] wb_data;
  logic [2:0]      dbg_addr;
  logic [nbit-1:0] dbg_data;

  // Instruction source / ALU / debug side
  modport master (
    output in_valid, in_instr, alu_result, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_sel, alu_shin, wb_valid, wb_rd, wb_data, dbg_data
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_instr, alu_result, dbg_addr,
    output in_ready, alu_a, alu_b, alu_sel, alu_shin, wb_valid, wb_rd, wb_data, dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
// 8 x nbit register file: two combinational operand reads, one combinational
// debug read, one synchronous write port, async reset clears every entry.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned nbit = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  input  logic [RegAddrW-1:0] dbg_addr_i,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [nbit-1:0]     wdata_i,
  output logic [nbit-1:0]     rdata_a_o,
  output logic [nbit-1:0]     rdata_b_o,
  output logic [nbit-1:0]     dbg_data_o
);

  logic [nbit-1:0] mem_q [NREGS];
  logic [nbit-1:0] mem_d [NREGS];

  // Next-state: only the addressed entry changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issue and write-back stage around the external combinational ALU. One
// instruction in flight: IDLE accepts, EXEC lets the ALU settle, WB presents
// the result for one cycle and commits it to the register file.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned nbit = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_issue_if.slave bus
);

  logic [1:0]          state_q, state_d;
  logic [nbit-1:0]     alu_a_q, alu_a_d;
  logic [nbit-1:0]     alu_b_q, alu_b_d;
  logic [2:0]          alu_sel_q, alu_sel_d;
  logic                alu_shin_q, alu_shin_d;
  logic [RegAddrW-1:0] rd_q, rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic [RegAddrW-1:0] wb_rd_q, wb_rd_d;
  logic [nbit-1:0]     wb_data_q, wb_data_d;

  logic [RegAddrW-1:0] rs1, rs2;
  logic [nbit-1:0]     rf_rdata_a, rf_rdata_b;
  logic                rf_we;
  logic                accept;
  logic                unused_rsvd;

  assign rs1         = bus.in_instr[OpRs1Lsb +: RegAddrW];
  assign rs2         = bus.in_instr[OpRs2Lsb +: RegAddrW];
  assign accept      = (state_q == StIdle) && bus.in_valid;
  // Commit happens on the edge that leaves WB
  assign rf_we       = (state_q == StWb);
  assign unused_rsvd = ^bus.in_instr[1:0];

  alu_regfile #(
    .nbit (nbit)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_a_i  (rs1),
    .raddr_b_i  (rs2),
    .dbg_addr_i (bus.dbg_addr),
    .we_i       (rf_we),
    .waddr_i    (wb_rd_q),
    .wdata_i    (wb_data_q),
    .rdata_a_o  (rf_rdata_a),
    .rdata_b_o  (rf_rdata_b),
    .dbg_data_o (bus.dbg_data)
  );

  // Next-state: decode on accept, capture ALU result in EXEC, retire in WB
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    alu_shin_d = alu_shin_q;
    rd_d       = rd_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_load_imm(bus.in_instr)) begin
            wb_data_d  = nbit'(bus.in_instr[LiImmLsb +: LiImmWidth]);
            wb_rd_d    = bus.in_instr[LiRdLsb +: RegAddrW];
            wb_valid_d = 1'b1;
            state_d    = StWb;
          end else begin
            alu_a_d    = rf_rdata_a;
            alu_b_d    = rf_rdata_b;
            alu_sel_d  = bus.in_instr[OpSelLsb +: 3];
            alu_shin_d = bus.in_instr[OpShinBit];
            rd_d       = bus.in_instr[OpRdLsb +: RegAddrW];
            state_d    = StExec;
          end
        end
      end
      StExec: begin
        wb_data_d  = bus.alu_result;
        wb_rd_d    = rd_q;
        wb_valid_d = 1'b1;
        state_d    = StWb;
      end
      StWb: begin
        wb_valid_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        wb_valid_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      alu_shin_q <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      alu_shin_q <= alu_shin_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_sel  = alu_sel_q;
  assign bus.alu_shin = alu_shin_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic,
// compared every cycle against a cycle-count based behavioural model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int unsigned NB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;
  logic rand_dbg = 1'b0;
  logic [15:0] dut_wb_q [$];

  alu_issue_if #(.nbit(NB)) bus ();

  alu_issue #(.nbit(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational ALU that sits beside the stage
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] sel, input logic shin);
    case (sel)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAndL:  return {15'd0, (a != 0) && (b != 0)};
      OpOrL:   return {15'd0, (a != 0) || (b != 0)};
      OpXor:   return a ^ b;
      OpNot:   return ~a;
      OpShl:   return a << shin;
      default: return a >> shin;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_shin);

  function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 4'b0000, imm};
  endfunction

  function automatic logic [15:0] enc_op(input logic [2:0] sel, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2,
                                         input logic shin);
    return {1'b0, sel, rd, rs1, rs2, shin, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: m_cnt counts the busy cycles left after acceptance.
  // Result of an ALU op is known at accept time from the model register file.
  logic [15:0] m_rf [8];
  int          m_cnt;
  logic [2:0]  m_wb_rd;
  logic [15:0] m_wb_data;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_sel;
  logic        m_shin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] <= '0;
      m_cnt     <= 0;
      m_wb_rd   <= '0;
      m_wb_data <= '0;
      m_a       <= '0;
      m_b       <= '0;
      m_sel     <= '0;
      m_shin    <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_rf[m_wb_rd] <= m_wb_data;
    end else if (bus.in_valid) begin
      if (bus.in_instr[15]) begin
        m_cnt     <= 1;
        m_wb_rd   <= bus.in_instr[14:12];
        m_wb_data <= {8'h00, bus.in_instr[7:0]};
      end else begin
        m_cnt     <= 2;
        m_a       <= m_rf[bus.in_instr[8:6]];
        m_b       <= m_rf[bus.in_instr[5:3]];
        m_sel     <= bus.in_instr[14:12];
        m_shin    <= bus.in_instr[2];
        m_wb_rd   <= bus.in_instr[11:9];
        m_wb_data <= alu_f(m_rf[bus.in_instr[8:6]], m_rf[bus.in_instr[5:3]],
                           bus.in_instr[14:12], bus.in_instr[2]);
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_cnt == 0));
      chk("wb_valid", 32'(bus.wb_valid), 32'(m_cnt == 1));
      if (m_cnt == 1) begin
        chk("wb_rd", 32'(bus.wb_rd), 32'(m_wb_rd));
        chk("wb_data", 32'(bus.wb_data), 32'(m_wb_data));
      end
      if (bus.wb_valid) dut_wb_q.push_back(bus.wb_data);
      chk("alu_a", 32'(bus.alu_a), 32'(m_a));
      chk("alu_b", 32'(bus.alu_b), 32'(m_b));
      chk("alu_sel", 32'(bus.alu_sel), 32'(m_sel));
      chk("alu_shin", 32'(bus.alu_shin), 32'(m_shin));
      chk("dbg_data", 32'(bus.dbg_data), 32'(m_rf[bus.dbg_addr]));
    end
  end

  always @(posedge clk) begin
    if (rand_dbg) begin
      #3;
      bus.dbg_addr <= 3'($urandom);
    end
  end

  // Present a word and hold it until accepted; returns the accept cycle
  task automatic issue(input logic [15:0] w, output int acc);
    int n = 0;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      acc = -1;
    end else begin
      @(posedge clk);
      #2;
      acc = cyc;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("idle_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] addr, input logic [15:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk(name, 32'(bus.dbg_data), 32'(exp));
  endtask

  function automatic logic [15:0] wb_at(input int idx);
    if (idx < dut_wb_q.size()) return dut_wb_q[idx];
    return 16'hDEAD;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, gap;
    logic [15:0] w;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    for (int i = 0; i < 8; i++) dbg_chk("reset_rf", 3'(i), 16'h0000);

    // Load and add, held back-to-back
    issue(enc_li(3'd1, 8'd5), a0);
    issue(enc_li(3'd2, 8'd3), a1);
    chk("li_spacing", 32'(a1 - a0), 32'd2);
    issue(enc_op(OpAdd, 3'd3, 3'd1, 3'd2, 1'b0), a0);
    #1;
    chk("exec_alu_a", 32'(bus.alu_a), 32'd5);
    chk("exec_alu_b", 32'(bus.alu_b), 32'd3);
    chk("exec_alu_sel", 32'(bus.alu_sel), 32'(OpAdd));
    wait_idle();
    chk("wb0_li5", 32'(wb_at(0)), 32'h5);
    chk("wb1_li3", 32'(wb_at(1)), 32'h3);
    chk("wb2_add", 32'(wb_at(2)), 32'h8);
    dbg_chk("dbg_r3", 3'd3, 16'd8);
    chk("model_r3", 32'(m_rf[3]), 32'd8);

    // Subtract wrap, then a stalled word during EXEC and WB
    issue(enc_op(OpSub, 3'd4, 3'd2, 3'd1, 1'b0), a0);
    bus.in_instr = enc_op(OpSub, 3'd7, 3'd1, 3'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_alu_a", 32'(bus.alu_a), 32'd3);
      chk("stall_alu_b", 32'(bus.alu_b), 32'd5);
      chk("stall_alu_sel", 32'(bus.alu_sel), 32'(OpSub));
    end
    issue(enc_op(OpSub, 3'd7, 3'd1, 3'd2, 1'b0), a1);
    chk("op_spacing", 32'(a1 - a0), 32'd3);
    wait_idle();
    chk("wb3_sub_wrap", 32'(wb_at(3)), 32'hFFFE);
    chk("wb4_sub", 32'(wb_at(4)), 32'h0002);
    dbg_chk("dbg_r4", 3'd4, 16'hFFFE);

    // Shift with self-overwrite
    issue(enc_li(3'd5, 8'h81), a0);
    issue(enc_op(OpShl, 3'd5, 3'd5, 3'd5, 1'b1), a0);
    issue(enc_op(OpShr, 3'd5, 3'd5, 3'd5, 1'b1), a0);
    wait_idle();
    chk("wb5_li81", 32'(wb_at(5)), 32'h0081);
    chk("wb6_shl", 32'(wb_at(6)), 32'h0102);
    chk("wb7_shr", 32'(wb_at(7)), 32'h0081);
    dbg_chk("dbg_r5", 3'd5, 16'h0081);

    // Reset during EXEC aborts the write
    issue(enc_op(OpAdd, 3'd6, 3'd1, 3'd2, 1'b0), a0);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("rst_alu_shin", 32'(bus.alu_shin), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    end
    dbg_chk("dbg_r6_aborted", 3'd6, 16'h0000);
    dbg_chk("dbg_r1_cleared", 3'd1, 16'h0000);

    // Random traffic with random gaps and random debug reads
    rand_dbg = 1'b1;
    for (int k = 0; k < 200; k++) begin
      w = 16'($urandom);
      issue(w, a0);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_instr = 16'($urandom);
        repeat (gap) @(posedge clk);
        #2;
      end
    end
    wait_idle();
    rand_dbg = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) dbg_chk("final_rf", 3'(i), m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
